// File: rtl/hg_pkg.sv
// Shared types, constants and helpers for the Halli Galli table controller.
package hg_pkg;

   // One laid card; count 0 means no card on the table.
   typedef struct packed {
      logic [2:0] count;
      logic [1:0] fruit;
   } card_t;

   // Two-digit decimal score kept directly in BCD.
   typedef struct packed {
      logic [3:0] tens;
      logic [3:0] units;
   } bcd_t;

   // Segment codes, bit order {g,f,e,d,c,b,a}, active-high.
   localparam logic [6:0] SEG_0     = 7'h3F;
   localparam logic [6:0] SEG_1     = 7'h06;
   localparam logic [6:0] SEG_2     = 7'h5B;
   localparam logic [6:0] SEG_3     = 7'h4F;
   localparam logic [6:0] SEG_4     = 7'h66;
   localparam logic [6:0] SEG_5     = 7'h6D;
   localparam logic [6:0] SEG_6     = 7'h7D;
   localparam logic [6:0] SEG_7     = 7'h07;
   localparam logic [6:0] SEG_8     = 7'h7F;
   localparam logic [6:0] SEG_9     = 7'h6F;
   localparam logic [6:0] SEG_BLANK = 7'h00;

   // Digit slots, 7 = leftmost.
   localparam logic [2:0] DIG_P1_COUNT = 3'd7;
   localparam logic [2:0] DIG_P1_FRUIT = 3'd6;
   localparam logic [2:0] DIG_P2_COUNT = 3'd5;
   localparam logic [2:0] DIG_P2_FRUIT = 3'd4;
   localparam logic [2:0] DIG_P1_TENS  = 3'd3;
   localparam logic [2:0] DIG_P1_UNITS = 3'd2;
   localparam logic [2:0] DIG_P2_TENS  = 3'd1;
   localparam logic [2:0] DIG_P2_UNITS = 3'd0;

   // A card may only be laid with 1..5 fruits.
   function automatic logic card_valid(input logic [2:0] count);
      return (count != 3'd0) && (count <= 3'd5);
   endfunction

   // True when some fruit totals exactly five on the table.
   function automatic logic ring_ok(input card_t a, input card_t b);
      logic [3:0] sum;
      sum = {1'b0, a.count} + {1'b0, b.count};
      if (a.fruit == b.fruit) begin
         return (sum == 4'd5);
      end
      return (a.count == 3'd5) || (b.count == 3'd5);
   endfunction

   // Saturating BCD increment up to max.
   function automatic bcd_t bcd_inc(input bcd_t s, input bcd_t max);
      bcd_t r;
      r = s;
      if (s != max) begin
         if (s.units == 4'd9) begin
            r.units = 4'd0;
            r.tens  = s.tens + 4'd1;
         end else begin
            r.units = s.units + 4'd1;
         end
      end
      return r;
   endfunction

   // Saturating BCD decrement down to zero.
   function automatic bcd_t bcd_dec(input bcd_t s);
      bcd_t r;
      r = s;
      if (s != '0) begin
         if (s.units == 4'd0) begin
            r.units = 4'd9;
            r.tens  = s.tens - 4'd1;
         end else begin
            r.units = s.units - 4'd1;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/hg_seg_decoder.sv
// Combinational 7-segment decoder with blanking; values above 9 show blank.
module hg_seg_decoder
   import hg_pkg::*;
(
   input  logic [3:0] value_i,
   input  logic       blank_i,
   output logic [6:0] seg_o
);

   // Map a decimal digit to its segment pattern
   always_comb begin
      seg_o = SEG_BLANK;
      if (!blank_i) begin
         case (value_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_BLANK;
         endcase
      end
   end

endmodule

// File: rtl/halli_galli_top.sv
// Two-player Halli Galli controller: card entry, bell judging, scores and
// a multiplexed 8-digit display.
module halli_galli_top
   import hg_pkg::*;
#(
   parameter int unsigned SCAN_DIV  = 10000,
   parameter int unsigned SCORE_MAX = 99
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       b1,
   input  logic       b2,
   input  logic       b3,
   input  logic       b4,
   input  logic       b5,
   input  logic       b6,
   input  logic       b7,
   input  logic       b8,
   input  logic       b9,
   input  logic       b10,
   input  logic       b11,
   input  logic       b12,
   output logic [6:0] seg_display,
   output logic [7:0] seg_position
);

   localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
   localparam bcd_t SCORE_MAX_BCD = '{tens: 4'(SCORE_MAX / 10), units: 4'(SCORE_MAX % 10)};

   logic [11:0] btn_raw;
   logic [11:0] sync1_q, sync2_q;
   logic [4:0]  code1, code2;
   logic        bell1, bell2;
   logic [1:0]  bell_prev_q;
   logic        ring1, ring2;
   logic [4:0]  cap1_q, cap1_d, cap2_q, cap2_d;
   logic        commit1, commit2;
   card_t       card1_q, card1_d, card2_q, card2_d;
   bcd_t        score1_q, score1_d, score2_q, score2_d;
   logic        win, cards_clear;
   logic [CNT_W-1:0] scan_q;
   logic [2:0]  idx_q;
   logic [3:0]  dig_val;
   logic        dig_blank;
   logic [6:0]  seg_next;

   assign btn_raw = {b12, b11, b10, b9, b8, b7, b6, b5, b4, b3, b2, b1};

   // Two-flop synchronizer on all buttons
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= btn_raw;
         sync2_q <= sync1_q;
      end
   end

   // Card code is {fruit, count}, bell sits above it
   assign code1 = sync2_q[4:0];
   assign bell1 = sync2_q[5];
   assign code2 = sync2_q[10:6];
   assign bell2 = sync2_q[11];
   assign ring1 = bell1 & ~bell_prev_q[0];
   assign ring2 = bell2 & ~bell_prev_q[1];

   // Capture OR-accumulates while any card button is held; commit on full release
   always_comb begin
      cap1_d  = cap1_q;
      cap2_d  = cap2_q;
      commit1 = 1'b0;
      commit2 = 1'b0;
      if (code1 != 5'd0) begin
         cap1_d = cap1_q | code1;
      end else if (cap1_q != 5'd0) begin
         cap1_d  = 5'd0;
         commit1 = card_valid(cap1_q[2:0]);
      end
      if (code2 != 5'd0) begin
         cap2_d = cap2_q | code2;
      end else if (cap2_q != 5'd0) begin
         cap2_d  = 5'd0;
         commit2 = card_valid(cap2_q[2:0]);
      end
   end

   // Judge bells on the pre-commit table, then apply card commits
   always_comb begin
      card1_d     = card1_q;
      card2_d     = card2_q;
      score1_d    = score1_q;
      score2_d    = score2_q;
      cards_clear = 1'b0;
      win         = ring_ok(card1_q, card2_q);
      if (ring1) begin
         if (win) begin
            score1_d    = bcd_inc(score1_q, SCORE_MAX_BCD);
            cards_clear = 1'b1;
         end else begin
            score1_d = bcd_dec(score1_q);
         end
      end
      // P2 only counts if P1 did not already take the table this cycle
      if (ring2 && !cards_clear) begin
         if (win) begin
            score2_d    = bcd_inc(score2_q, SCORE_MAX_BCD);
            cards_clear = 1'b1;
         end else begin
            score2_d = bcd_dec(score2_q);
         end
      end
      if (cards_clear) begin
         card1_d = '0;
         card2_d = '0;
      end
      if (commit1) begin
         card1_d = '{count: cap1_q[2:0], fruit: cap1_q[4:3]};
      end
      if (commit2) begin
         card2_d = '{count: cap2_q[2:0], fruit: cap2_q[4:3]};
      end
   end

   // Game state registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bell_prev_q <= '0;
         cap1_q      <= '0;
         cap2_q      <= '0;
         card1_q     <= '0;
         card2_q     <= '0;
         score1_q    <= '0;
         score2_q    <= '0;
      end else begin
         bell_prev_q <= {bell2, bell1};
         cap1_q      <= cap1_d;
         cap2_q      <= cap2_d;
         card1_q     <= card1_d;
         card2_q     <= card2_d;
         score1_q    <= score1_d;
         score2_q    <= score2_d;
      end
   end

   // Scan timer; digit index walks 7 down to 0 and wraps
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         scan_q <= '0;
         idx_q  <= 3'd7;
      end else if (scan_q == CNT_LAST) begin
         scan_q <= '0;
         idx_q  <= idx_q - 3'd1;
      end else begin
         scan_q <= scan_q + CNT_W'(1);
      end
   end

   // Select the value shown in the current digit slot
   always_comb begin
      dig_val   = 4'd0;
      dig_blank = 1'b1;
      unique case (idx_q)
         DIG_P1_COUNT: begin
            dig_val   = {1'b0, card1_q.count};
            dig_blank = (card1_q.count == 3'd0);
         end
         DIG_P1_FRUIT: begin
            dig_val   = {2'b00, card1_q.fruit};
            dig_blank = (card1_q.count == 3'd0);
         end
         DIG_P2_COUNT: begin
            dig_val   = {1'b0, card2_q.count};
            dig_blank = (card2_q.count == 3'd0);
         end
         DIG_P2_FRUIT: begin
            dig_val   = {2'b00, card2_q.fruit};
            dig_blank = (card2_q.count == 3'd0);
         end
         DIG_P1_TENS: begin
            dig_val   = score1_q.tens;
            dig_blank = 1'b0;
         end
         DIG_P1_UNITS: begin
            dig_val   = score1_q.units;
            dig_blank = 1'b0;
         end
         DIG_P2_TENS: begin
            dig_val   = score2_q.tens;
            dig_blank = 1'b0;
         end
         DIG_P2_UNITS: begin
            dig_val   = score2_q.units;
            dig_blank = 1'b0;
         end
         default: begin
            dig_val   = 4'd0;
            dig_blank = 1'b1;
         end
      endcase
   end

   hg_seg_decoder u_seg_decoder (
      .value_i (dig_val),
      .blank_i (dig_blank),
      .seg_o   (seg_next)
   );

   // Registered display outputs so position and segments switch together
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         seg_position <= 8'hFF;
         seg_display  <= 7'h00;
      end else begin
         seg_position <= ~(8'd1 << idx_q);
         seg_display  <= seg_next;
      end
   end

endmodule

// File: tb/tb_halli_galli_top.sv
// Self-checking bench: directed game scenarios plus random play, checked
// against a table-level model through the scanned display.
module tb_halli_galli_top;

   localparam int unsigned SCAN_DIV  = 2;
   localparam int unsigned SCORE_MAX = 3;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [12:1] b   = '0;
   logic [6:0]  seg_display;
   logic [7:0]  seg_position;

   int tests = 0;
   int fails = 0;

   // Model of the table
   int m_cnt[2];
   int m_fru[2];
   int m_score[2];

   logic [6:0] seg_tab [11] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D,
                                7'h7D, 7'h07, 7'h7F, 7'h6F, 7'h00};

   halli_galli_top #(
      .SCAN_DIV  (SCAN_DIV),
      .SCORE_MAX (SCORE_MAX)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .b1           (b[1]),
      .b2           (b[2]),
      .b3           (b[3]),
      .b4           (b[4]),
      .b5           (b[5]),
      .b6           (b[6]),
      .b7           (b[7]),
      .b8           (b[8]),
      .b9           (b[9]),
      .b10          (b[10]),
      .b11          (b[11]),
      .b12          (b[12]),
      .seg_display  (seg_display),
      .seg_position (seg_position)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
      $fatal(1, "watchdog");
   end

   function automatic logic [4:0] card(input int cnt, input int fr);
      logic [2:0] c;
      logic [1:0] f;
      c = 3'(cnt);
      f = 2'(fr);
      return {f, c};
   endfunction

   function automatic void model_reset();
      for (int p = 0; p < 2; p++) begin
         m_cnt[p]   = 0;
         m_fru[p]   = 0;
         m_score[p] = 0;
      end
   endfunction

   function automatic bit table_has_five();
      int tot[4];
      for (int f = 0; f < 4; f++) tot[f] = 0;
      for (int p = 0; p < 2; p++) begin
         if (m_cnt[p] != 0) tot[m_fru[p]] += m_cnt[p];
      end
      for (int f = 0; f < 4; f++) begin
         if (tot[f] == 5) return 1'b1;
      end
      return 1'b0;
   endfunction

   function automatic void model_rings(input bit r1, input bit r2);
      bit taken;
      bit ok;
      taken = 1'b0;
      ok    = table_has_five();
      for (int p = 0; p < 2; p++) begin
         if ((p == 0 ? r1 : r2) && !taken) begin
            if (ok) begin
               if (m_score[p] < SCORE_MAX) m_score[p]++;
               m_cnt[0] = 0; m_fru[0] = 0;
               m_cnt[1] = 0; m_fru[1] = 0;
               taken = 1'b1;
            end else if (m_score[p] > 0) begin
               m_score[p]--;
            end
         end
      end
   endfunction

   function automatic void model_commit(input int p, input logic [4:0] code);
      int c;
      c = int'(code[2:0]);
      if (c >= 1 && c <= 5) begin
         m_cnt[p] = c;
         m_fru[p] = int'(code[4:3]);
      end
   endfunction

   function automatic logic [6:0] exp_seg(input int idx);
      case (idx)
         7: return (m_cnt[0] == 0) ? 7'h00 : seg_tab[m_cnt[0]];
         6: return (m_cnt[0] == 0) ? 7'h00 : seg_tab[m_fru[0]];
         5: return (m_cnt[1] == 0) ? 7'h00 : seg_tab[m_cnt[1]];
         4: return (m_cnt[1] == 0) ? 7'h00 : seg_tab[m_fru[1]];
         3: return seg_tab[m_score[0] / 10];
         2: return seg_tab[m_score[0] % 10];
         1: return seg_tab[m_score[1] / 10];
         0: return seg_tab[m_score[1] % 10];
         default: return 7'h00;
      endcase
   endfunction

   function automatic logic [4:0] rand_code();
      int unsigned sel;
      sel = $urandom_range(0, 9);
      if (sel < 2) return 5'd0;
      if (sel < 3) return 5'($urandom_range(1, 31));
      return card(int'($urandom_range(1, 5)), int'($urandom_range(0, 3)));
   endfunction

   // Press cards (two phases), then release cards and raise bells together
   task automatic step(input logic [4:0] p1a, input logic [4:0] p1b,
                       input logic [4:0] p2a, input logic [4:0] p2b,
                       input bit r1, input bit r2);
      logic [4:0] p1s;
      logic [4:0] p2s;
      p1s = (p1b != 5'd0) ? p1b : p1a;
      p2s = (p2b != 5'd0) ? p2b : p2a;
      @(negedge clk);
      b[5:1]  = p1a;
      b[11:7] = p2a;
      repeat (3) @(negedge clk);
      b[5:1]  = p1s;
      b[11:7] = p2s;
      repeat (3) @(negedge clk);
      b[5:1]  = '0;
      b[11:7] = '0;
      b[6]    = r1;
      b[12]   = r2;
      repeat (3) @(negedge clk);
      b[6]  = 1'b0;
      b[12] = 1'b0;
      repeat (5) @(negedge clk);
      model_rings(r1, r2);
      if ((p1a | p1s) != 5'd0) model_commit(0, p1a | p1s);
      if ((p2a | p2s) != 5'd0) model_commit(1, p2a | p2s);
   endtask

   // Watch one full scan frame and compare every digit with the model
   task automatic check_frame(input string tag);
      int idx;
      logic [6:0] exp;
      for (int k = 0; k < 8 * int'(SCAN_DIV); k++) begin
         @(negedge clk);
         idx = -1;
         for (int i = 0; i < 8; i++) begin
            if (seg_position == ~(8'd1 << i)) idx = i;
         end
         tests++;
         assert (idx >= 0) else begin
            fails++;
            $error("FAIL %s_pos: seg_position=%h expected one-hot-low", tag, seg_position);
         end
         if (idx >= 0) begin
            exp = exp_seg(idx);
            tests++;
            assert (seg_display === exp) else begin
               fails++;
               $error("FAIL %s_dig%0d: seg_display=%h expected %h", tag, idx, seg_display, exp);
            end
         end
      end
   endtask

   initial begin
      int exp_idx;
      logic [7:0] exp_pos;
      logic [4:0] c1a, c1b, c2a, c2b;

      model_reset();
      #1 rst = 1'b0;
      #20;
      tests++;
      assert (seg_position === 8'hFF) else begin
         fails++;
         $error("FAIL reset_pos: seg_position=%h expected ff", seg_position);
      end
      tests++;
      assert (seg_display === 7'h00) else begin
         fails++;
         $error("FAIL reset_seg: seg_display=%h expected 00", seg_display);
      end

      // Scan order right after reset release
      @(negedge clk);
      rst = 1'b1;
      for (int n = 1; n <= 20; n++) begin
         @(negedge clk);
         exp_idx = 7 - (((n - 1) / int'(SCAN_DIV)) % 8);
         exp_pos = ~(8'd1 << exp_idx);
         tests++;
         assert (seg_position === exp_pos) else begin
            fails++;
            $error("FAIL scan_pos%0d: seg_position=%h expected %h", n, seg_position, exp_pos);
         end
         tests++;
         assert (seg_display === exp_seg(exp_idx)) else begin
            fails++;
            $error("FAIL scan_seg%0d: seg_display=%h expected %h", n, seg_display,
                   exp_seg(exp_idx));
         end
      end
      check_frame("init");

      // Repeated card replacement by P1
      for (int r = 0; r < 3; r++) begin
         step(card(1, 0), 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
         check_frame("lay1");
         step(card(3, 0), 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
         check_frame("lay3");
      end

      // Same fruit summing to five, P1 rings
      step(card(2, 1), 5'd0, card(3, 1), 5'd0, 1'b0, 1'b0);
      step(5'd0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
      check_frame("p1_win");

      // Wrong ring by P2 at score 0
      step(card(4, 0), 5'd0, card(4, 2), 5'd0, 1'b0, 1'b0);
      step(5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
      check_frame("p2_wrong_sat0");

      // Both bells, P1 correct
      step(card(5, 3), 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
      step(5'd0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1);
      check_frame("both_p1_win");

      // Invalid codes leave the card alone
      step(card(2, 1), 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
      step(card(6, 0), 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
      check_frame("inv_cnt6");
      step(card(0, 2), 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
      check_frame("inv_cnt0");

      // Commit in the same cycle as a correct ring survives the clear
      step(5'd0, 5'd0, card(3, 1), 5'd0, 1'b0, 1'b0);
      step(card(4, 2), 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
      check_frame("commit_vs_clear");

      // Score ceiling
      for (int r = 0; r < 3; r++) begin
         step(card(5, 0), 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
         step(5'd0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
         check_frame("p1_ceiling");
      end

      // Wrong rings down to zero, then both wrong together
      step(card(1, 0), 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
      step(5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
      step(5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
      check_frame("p2_floor");
      step(5'd0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1);
      check_frame("both_wrong");

      // Random play
      for (int r = 0; r < 40; r++) begin
         c1a = rand_code();
         c2a = rand_code();
         c1b = ($urandom_range(0, 3) == 0) ? rand_code() : 5'd0;
         c2b = ($urandom_range(0, 3) == 0) ? rand_code() : 5'd0;
         step(c1a, c1b, c2a, c2b, ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0));
         check_frame("rand");
      end

      // Reset while a card is held, then release after reset
      @(negedge clk);
      b[5:1] = card(2, 3);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      tests++;
      assert (seg_position === 8'hFF) else begin
         fails++;
         $error("FAIL midrst_pos: seg_position=%h expected ff", seg_position);
      end
      repeat (3) @(negedge clk);
      rst = 1'b1;
      repeat (4) @(negedge clk);
      b[5:1] = '0;
      repeat (5) @(negedge clk);
      model_reset();
      model_commit(0, card(2, 3));
      check_frame("midrst");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
